// File: rtl/sum_controller_if.sv
// Host and datapath connection bundle for the summation controller.
// master: host plus datapath side (drives requests, done and result).
// slave: the controller itself.
interface sum_controller_if;
  logic        start;
  logic        abort;
  logic        ack;
  logic        busy;
  logic        res_valid;
  logic [15:0] res_data;
  logic        err;
  logic        dp_clr_n;
  logic        ld_sum;
  logic        ld_counter;
  logic        en_sum;
  logic        en_counter;
  logic        done;
  logic [15:0] result;

  modport master (
    output start, abort, ack, done, result,
    input  busy, res_valid, res_data, err,
    input  dp_clr_n, ld_sum, ld_counter, en_sum, en_counter
  );

  modport slave (
    input  start, abort, ack, done, result,
    output busy, res_valid, res_data, err,
    output dp_clr_n, ld_sum, ld_counter, en_sum, en_counter
  );
endinterface

// File: rtl/sum_controller.sv
// Summation controller: sequences an external accumulate/count datapath
// through clear, load and run phases, captures its result, and reports
// a timeout if the datapath never signals completion.
// Outputs are Moore outputs: they are decoded from the next state and
// registered, so they track the current state with no combinational path
// from the inputs.
module sum_controller #(
  parameter int unsigned TIMEOUT = 200
) (
  input logic             clk,
  input logic             rst,
  sum_controller_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_RUN    = 3'd3,
    ST_SETTLE = 3'd4,
    ST_HOLD   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  // Timer value seen during the last RUN cycle allowed before timeout.
  localparam logic [7:0] TIMER_LAST_C = 8'(TIMEOUT - 1);

  state_t      state_r;
  state_t      state_s;
  logic [7:0]  timer_r;
  logic [15:0] res_data_r;

  logic busy_r, res_valid_r, err_r, dp_clr_n_r;
  logic ld_sum_r, ld_counter_r, en_sum_r, en_counter_r;
  logic busy_s, res_valid_s, err_s, dp_clr_n_s;
  logic ld_sum_s, ld_counter_s, en_sum_s, en_counter_s;

  // State register plus registered copy of the state-decoded outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      res_valid_r  <= 1'b0;
      err_r        <= 1'b0;
      dp_clr_n_r   <= 1'b1;
      ld_sum_r     <= 1'b0;
      ld_counter_r <= 1'b0;
      en_sum_r     <= 1'b0;
      en_counter_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      busy_r       <= busy_s;
      res_valid_r  <= res_valid_s;
      err_r        <= err_s;
      dp_clr_n_r   <= dp_clr_n_s;
      ld_sum_r     <= ld_sum_s;
      ld_counter_r <= ld_counter_s;
      en_sum_r     <= en_sum_s;
      en_counter_r <= en_counter_s;
    end
  end

  // Next-state logic; abort outranks done and timeout in the active phases.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_s = ST_CLEAR;
        else           state_s = ST_IDLE;
      end
      ST_CLEAR: begin
        if (bus.abort) state_s = ST_IDLE;
        else           state_s = ST_LOAD;
      end
      ST_LOAD: begin
        if (bus.abort) state_s = ST_IDLE;
        else           state_s = ST_RUN;
      end
      ST_RUN: begin
        if (bus.abort)                    state_s = ST_IDLE;
        else if (bus.done)                state_s = ST_SETTLE;
        else if (timer_r == TIMER_LAST_C) state_s = ST_ERROR;
        else                              state_s = ST_RUN;
      end
      ST_SETTLE: begin
        if (bus.abort) state_s = ST_IDLE;
        else           state_s = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.ack) state_s = ST_IDLE;
        else         state_s = ST_HOLD;
      end
      ST_ERROR: begin
        if (bus.ack) state_s = ST_IDLE;
        else         state_s = ST_ERROR;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode of the state being entered; registered above.
  always_comb begin
    busy_s       = 1'b1;
    res_valid_s  = 1'b0;
    err_s        = 1'b0;
    dp_clr_n_s   = 1'b1;
    ld_sum_s     = 1'b0;
    ld_counter_s = 1'b0;
    en_sum_s     = 1'b0;
    en_counter_s = 1'b0;
    case (state_s)
      ST_IDLE:   busy_s       = 1'b0;
      ST_CLEAR:  dp_clr_n_s   = 1'b0;
      ST_LOAD: begin
        ld_sum_s     = 1'b1;
        ld_counter_s = 1'b1;
      end
      ST_RUN: begin
        en_sum_s     = 1'b1;
        en_counter_s = 1'b1;
      end
      ST_SETTLE: busy_s       = 1'b1;
      ST_HOLD:   res_valid_s  = 1'b1;
      ST_ERROR:  err_s        = 1'b1;
      default:   busy_s       = 1'b0;
    endcase
  end

  // Run timer: zeroed while loading, counts each RUN cycle, else holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_r <= 8'd0;
    end else if (state_r == ST_LOAD) begin
      timer_r <= 8'd0;
    end else if (state_r == ST_RUN) begin
      timer_r <= timer_r + 8'd1;
    end else begin
      timer_r <= timer_r;
    end
  end

  // Result capture only on a completed SETTLE; an abort there skips it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_data_r <= 16'd0;
    end else if ((state_r == ST_SETTLE) && (state_s == ST_HOLD)) begin
      res_data_r <= bus.result;
    end else begin
      res_data_r <= res_data_r;
    end
  end

  assign bus.busy       = busy_r;
  assign bus.res_valid  = res_valid_r;
  assign bus.res_data   = res_data_r;
  assign bus.err        = err_r;
  assign bus.dp_clr_n   = dp_clr_n_r;
  assign bus.ld_sum     = ld_sum_r;
  assign bus.ld_counter = ld_counter_r;
  assign bus.en_sum     = en_sum_r;
  assign bus.en_counter = en_counter_r;

endmodule

// File: doc/sum_controller.md
SUM_CONTROLLER -- requirements
Module: sum_controller

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 200, maximum RUN cycles allowed before error (legal 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  host request to begin a summation; sampled only in IDLE.
REQ-005 abort  input  1  host cancel of an in-progress summation.
REQ-006 ack  input  1  host acknowledge of a result or error.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 res_valid  output  1  high while res_data holds an unacknowledged result.
REQ-009 res_data  output  16  captured summation result.
REQ-010 err  output  1  high while an unacknowledged timeout is pending.
REQ-011 dp_clr_n  output  1  active-low clear to the datapath reset pin.
REQ-012 ld_sum, ld_counter  output  1 each  datapath load-zero strobes.
REQ-013 en_sum, en_counter  output  1 each  datapath accumulate/count enables.
REQ-014 done  input  1  datapath completion flag; sticky until datapath cleared.
REQ-015 result  input  16  datapath result; valid one cycle after done rises.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, LOAD, RUN, SETTLE, HOLD, ERROR in a registered state vector; all outputs except res_data SHALL be decoded from the current state only.
REQ-017 Output decode SHALL be: CLEAR: dp_clr_n=0; LOAD: ld_sum=ld_counter=1; RUN: en_sum=en_counter=1; HOLD: res_valid=1; ERROR: err=1; otherwise these are 0 and dp_clr_n=1.
REQ-018 IDLE SHALL go to CLEAR when start=1, else stay; start in any other state SHALL be ignored.
REQ-019 CLEAR SHALL go to LOAD and LOAD to RUN unconditionally, so the first RUN cycle begins 3 edges after start is sampled.
REQ-020 An 8-bit run timer SHALL be zeroed in LOAD and increment by 1 on each RUN cycle.
REQ-021 RUN SHALL go to SETTLE when done=1; when done=0 and timer==TIMEOUT-1 it SHALL go to ERROR; otherwise stay.
REQ-022 SETTLE SHALL last exactly one cycle, and on its closing edge res_data SHALL load result and the state SHALL go to HOLD.
REQ-023 HOLD SHALL go to IDLE on ack=1; ERROR SHALL go to IDLE on ack=1; both otherwise stay.
REQ-024 res_data SHALL change only on the SETTLE exit edge and SHALL retain its value through IDLE, abort and ERROR.
REQ-025 abort=1 in CLEAR, LOAD, RUN or SETTLE SHALL force IDLE on the next edge, without updating res_data or raising err.
REQ-026 abort SHALL take priority over done and timeout.
REQ-027 abort SHALL be ignored in IDLE, HOLD and ERROR.
REQ-028 start and ack asserted together in HOLD SHALL return to IDLE only; start SHALL be re-sampled in IDLE on a later cycle.
REQ-029 done=1 in any state other than RUN SHALL have no effect.

Reset
REQ-030 rst=0 SHALL immediately force IDLE, timer=0, res_data=0, busy=res_valid=err=0, all strobes and enables 0, and dp_clr_n=1.
REQ-031 Reset mid-RUN SHALL leave the block in IDLE after release, with no result or error reported.

Verification
REQ-032 Start with a datapath model that asserts done after 101 RUN cycles and result=5050 -> busy rises 1 edge after start, res_valid=1 and res_data=16'd5050 2 edges after done, then IDLE after ack.
REQ-033 TIMEOUT=8 with done held 0 -> err=1 after exactly 8 RUN cycles, en_sum=0 in ERROR, IDLE after ack, and res_data unchanged.
REQ-034 abort on the 5th RUN cycle while done=1 -> IDLE next edge, res_valid=0, err=0, and res_data keeps its prior value 5050.
REQ-035 start pulses during RUN and HOLD, and start+ack together in HOLD -> no restart; a new run begins only on start sampled in IDLE.
REQ-036 rst asserted in RUN and in HOLD -> all outputs reach their reset values asynchronously, with dp_clr_n=1.
REQ-037 Sequence check: each run shows exactly one dp_clr_n low cycle, then one ld_sum/ld_counter cycle, then enables asserted contiguously.
